// File: rtl/prach_mixer.sv
// -----------------------------------------------------------------------------
// prach_mixer
//
// Complex down-conversion mixer for the time-interleaved PRACH datapath.
// Each 8-channel TDM IQ sample is multiplied by the conjugate oscillator
// (cos - j*sin) that the PRACH NCO produces for the same channel.
//
//   dout_i = round(a_i*cos + a_q*sin)
//   dout_q = round(a_q*cos - a_i*sin)
//
// The sample stream is delayed to line up with the NCO output. Any disagreement
// between the delayed stream and the NCO sideband raises a sticky flag.
//
// Parameters
//   NCO_LATENCY  NCO input-to-output latency in cycles (1..16), default 4
//   DW           IQ sample width, signed two's complement, default 16
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   din_i/din_q     input IQ sample (signed DW)
//   din_dv/din_chn  sample valid and channel (same signals that feed the NCO)
//   sync_in         frame sync (same pulse that feeds the NCO)
//   nco_cos/sin     NCO outputs, fi(1,16,14)
//   nco_dv/chn/sync NCO sideband outputs
//   dout_i/dout_q   mixed output, valid while dout_dv is high
//   dout_dv/chn     output valid and channel
//   sync_out        sync delayed by NCO_LATENCY + 3 cycles
//   align_err       sticky misalignment flag, cleared by err_clr
//   err_clr         synchronous clear for align_err (a new mismatch wins)
//
// Latency: din_* -> dout_* is NCO_LATENCY + 3 cycles; nco_* -> dout_* is 3.
//
// Build option: define PRACH_MIXER_SAT_EN to saturate the stage-3 reduction.
// Without it, stage 3 keeps the low DW bits, so results wrap.
// -----------------------------------------------------------------------------
module prach_mixer #(
  parameter int NCO_LATENCY = 4,
  parameter int DW          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic                 din_dv,
  input  logic [7:0]           din_chn,
  input  logic                 sync_in,
  input  logic signed [15:0]   nco_cos,
  input  logic signed [15:0]   nco_sin,
  input  logic                 nco_dv,
  input  logic [7:0]           nco_chn,
  input  logic                 nco_sync,
  output logic signed [DW-1:0] dout_i,
  output logic signed [DW-1:0] dout_q,
  output logic                 dout_dv,
  output logic [7:0]           dout_chn,
  output logic                 sync_out,
  output logic                 align_err,
  input  logic                 err_clr
);

  localparam int CW   = 16;        // NCO word width
  localparam int PW   = DW + CW;   // full product width
  localparam int SW   = PW + 1;    // sum of two products
  localparam int FRAC = 14;        // NCO fractional bits
  localparam int PIPE = 3;         // mixer stages after alignment

  localparam logic signed [SW-1:0] RND_HALF = SW'(1 << (FRAC - 1));

`ifdef PRACH_MIXER_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  genvar gi;

  // ---------------------------------------------------------------------------
  // Alignment shift register.
  // Tap 0 is the raw input. Tap gi+1 is the output of stage gi.
  // Only the valid and sync bits are reset. The data and channel bits are
  // don't-care while valid is low.
  // ---------------------------------------------------------------------------
  logic                 al_dv   [NCO_LATENCY+1];
  logic                 al_sync [NCO_LATENCY+1];
  logic [7:0]           al_chn  [NCO_LATENCY+1];
  logic signed [DW-1:0] al_i    [NCO_LATENCY+1];
  logic signed [DW-1:0] al_q    [NCO_LATENCY+1];

  assign al_dv[0]   = din_dv;
  assign al_sync[0] = sync_in;
  assign al_chn[0]  = din_chn;
  assign al_i[0]    = din_i;
  assign al_q[0]    = din_q;

  generate
    for (gi = 0; gi < NCO_LATENCY; gi++) begin : g_align
      logic                 dv_reg;
      logic                 sync_reg;
      logic [7:0]           chn_reg;
      logic signed [DW-1:0] i_reg;
      logic signed [DW-1:0] q_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dv_reg   <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          dv_reg   <= al_dv[gi];
          sync_reg <= al_sync[gi];
        end
      end

      always_ff @(posedge clk) begin
        chn_reg <= al_chn[gi];
        i_reg   <= al_i[gi];
        q_reg   <= al_q[gi];
      end

      assign al_dv[gi+1]   = dv_reg;
      assign al_sync[gi+1] = sync_reg;
      assign al_chn[gi+1]  = chn_reg;
      assign al_i[gi+1]    = i_reg;
      assign al_q[gi+1]    = q_reg;
    end
  endgenerate

  logic                 a_dv;
  logic                 a_sync;
  logic [7:0]           a_chn;
  logic signed [DW-1:0] a_i;
  logic signed [DW-1:0] a_q;

  assign a_dv   = al_dv[NCO_LATENCY];
  assign a_sync = al_sync[NCO_LATENCY];
  assign a_chn  = al_chn[NCO_LATENCY];
  assign a_i    = al_i[NCO_LATENCY];
  assign a_q    = al_q[NCO_LATENCY];

  // ---------------------------------------------------------------------------
  // Alignment check.
  // Valid and sync must match every cycle. The channel is only meaningful
  // while the delayed sample is valid.
  // The flag reports problems only; mixing proceeds regardless.
  // ---------------------------------------------------------------------------
  logic mismatch;
  logic align_err_reg;
  logic align_err_next;

  assign mismatch = (a_dv != nco_dv) ||
                    (a_sync != nco_sync) ||
                    (a_dv && (a_chn != nco_chn));

  always_comb begin
    align_err_next = align_err_reg;
    if (err_clr) begin
      align_err_next = 1'b0;
    end
    // A new mismatch overrides a clear in the same cycle.
    if (mismatch) begin
      align_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err_reg <= 1'b0;
    end else begin
      align_err_reg <= align_err_next;
    end
  end

  assign align_err = align_err_reg;

  // ---------------------------------------------------------------------------
  // Stage 1: four registered signed products.
  //   0: a_i*cos   1: a_q*sin   2: a_q*cos   3: a_i*sin
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] mul_a [4];
  logic signed [CW-1:0] mul_b [4];
  logic signed [PW-1:0] prod  [4];

  assign mul_a[0] = a_i;  assign mul_b[0] = nco_cos;
  assign mul_a[1] = a_q;  assign mul_b[1] = nco_sin;
  assign mul_a[2] = a_q;  assign mul_b[2] = nco_cos;
  assign mul_a[3] = a_i;  assign mul_b[3] = nco_sin;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_mul
      logic signed [PW-1:0] prod_reg;

      // Both operands are sign-extended to the full product width, so the
      // product is exact.
      always_ff @(posedge clk) begin
        prod_reg <= PW'(mul_a[gi]) * PW'(mul_b[gi]);
      end

      assign prod[gi] = prod_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 2: conjugate-multiply sums.
  // Rounding is half-up: add 2^13, then arithmetic shift right by 14.
  // The 33-bit sum cannot overflow, even for (-2^15)*(-2^15) products.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] sum_i;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] rnd_i_next;
  logic signed [SW-1:0] rnd_q_next;
  logic signed [SW-1:0] rnd_i_reg;
  logic signed [SW-1:0] rnd_q_reg;

  always_comb begin
    sum_i      = SW'(prod[0]) + SW'(prod[1]);
    sum_q      = SW'(prod[2]) - SW'(prod[3]);
    rnd_i_next = (sum_i + RND_HALF) >>> FRAC;
    rnd_q_next = (sum_q + RND_HALF) >>> FRAC;
  end

  always_ff @(posedge clk) begin
    rnd_i_reg <= rnd_i_next;
    rnd_q_reg <= rnd_q_next;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: reduce the rounded value to DW bits, then register the output.
  // ---------------------------------------------------------------------------
  function automatic logic signed [DW-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef PRACH_MIXER_SAT_EN
    if (v > SAT_MAX) begin
      reduce = SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      reduce = SAT_MIN[DW-1:0];
    end else begin
      reduce = v[DW-1:0];
    end
`else
    reduce = v[DW-1:0];
`endif
  endfunction

  logic signed [DW-1:0] dout_i_reg;
  logic signed [DW-1:0] dout_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_i_reg <= '0;
      dout_q_reg <= '0;
    end else begin
      dout_i_reg <= reduce(rnd_i_reg);
      dout_q_reg <= reduce(rnd_q_reg);
    end
  end

  assign dout_i = dout_i_reg;
  assign dout_q = dout_q_reg;

  // ---------------------------------------------------------------------------
  // Sideband pipeline.
  // Valid, channel and sync travel alongside the three mixer stages.
  // All of these bits are reset, so a reset discards in-flight samples at once.
  // ---------------------------------------------------------------------------
  logic       sd_dv   [PIPE+1];
  logic       sd_sync [PIPE+1];
  logic [7:0] sd_chn  [PIPE+1];

  assign sd_dv[0]   = a_dv;
  assign sd_sync[0] = a_sync;
  assign sd_chn[0]  = a_chn;

  generate
    for (gi = 0; gi < PIPE; gi++) begin : g_side
      logic       dv_reg;
      logic       sync_reg;
      logic [7:0] chn_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dv_reg   <= 1'b0;
          sync_reg <= 1'b0;
          chn_reg  <= '0;
        end else begin
          dv_reg   <= sd_dv[gi];
          sync_reg <= sd_sync[gi];
          chn_reg  <= sd_chn[gi];
        end
      end

      assign sd_dv[gi+1]   = dv_reg;
      assign sd_sync[gi+1] = sync_reg;
      assign sd_chn[gi+1]  = chn_reg;
    end
  endgenerate

  assign dout_dv  = sd_dv[PIPE];
  assign sync_out = sd_sync[PIPE];
  assign dout_chn = sd_chn[PIPE];

endmodule

// File: tb/tb_prach_mixer.sv
// -----------------------------------------------------------------------------
// tb_prach_mixer
//
// Self-checking bench for prach_mixer.
// An ideal NCO model delays the sample sideband and the oscillator values by
// the NCO latency. Each issued sample pushes its expected output onto a
// queue. A monitor pops the queue whenever dout_dv is high.
// -----------------------------------------------------------------------------
module tb_prach_mixer;

  localparam int LAT = 4;
  localparam int DW  = 16;

`ifdef PRACH_MIXER_SAT_EN
  localparam int OVF_P = 32767;
  localparam int OVF_N = -32768;
`else
  localparam int OVF_P = -2;
  localparam int OVF_N = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [DW-1:0] din_i;
  logic signed [DW-1:0] din_q;
  logic                 din_dv;
  logic [7:0]           din_chn;
  logic                 sync_in;
  logic signed [15:0]   nco_cos;
  logic signed [15:0]   nco_sin;
  logic                 nco_dv;
  logic [7:0]           nco_chn;
  logic                 nco_sync;
  logic signed [DW-1:0] dout_i;
  logic signed [DW-1:0] dout_q;
  logic                 dout_dv;
  logic [7:0]           dout_chn;
  logic                 sync_out;
  logic                 align_err;
  logic                 err_clr;

  // Oscillator values offered to the NCO model alongside each sample
  logic signed [15:0]   st_cos;
  logic signed [15:0]   st_sin;
  logic                 chn_skew;
  logic                 dv_flip;

  prach_mixer #(.NCO_LATENCY(LAT), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_i    (din_i),
    .din_q    (din_q),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .nco_cos  (nco_cos),
    .nco_sin  (nco_sin),
    .nco_dv   (nco_dv),
    .nco_chn  (nco_chn),
    .nco_sync (nco_sync),
    .dout_i   (dout_i),
    .dout_q   (dout_q),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .align_err(align_err),
    .err_clr  (err_clr)
  );

  // ---------------- ideal NCO model ----------------
  logic               m_dv   [LAT];
  logic               m_sync [LAT];
  logic [7:0]         m_chn  [LAT];
  logic signed [15:0] m_cos  [LAT];
  logic signed [15:0] m_sin  [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        m_dv[k]   <= 1'b0;
        m_sync[k] <= 1'b0;
        m_chn[k]  <= 8'd0;
        m_cos[k]  <= 16'sd0;
        m_sin[k]  <= 16'sd0;
      end
    end else begin
      m_dv[0]   <= din_dv;
      m_sync[0] <= sync_in;
      m_chn[0]  <= din_chn;
      m_cos[0]  <= st_cos;
      m_sin[0]  <= st_sin;
      for (int k = 1; k < LAT; k++) begin
        m_dv[k]   <= m_dv[k-1];
        m_sync[k] <= m_sync[k-1];
        m_chn[k]  <= m_chn[k-1];
        m_cos[k]  <= m_cos[k-1];
        m_sin[k]  <= m_sin[k-1];
      end
    end
  end

  assign nco_dv   = m_dv[LAT-1] ^ dv_flip;
  assign nco_sync = m_sync[LAT-1];
  assign nco_chn  = m_chn[LAT-1] + 8'(chn_skew);
  assign nco_cos  = m_cos[LAT-1];
  assign nco_sin  = m_sin[LAT-1];

  // ---------------- cycle counter ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [7:0]         chn;
    logic               sync;
    int                 cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference rounding: floor((x + 2^13) / 2^14), then reduce to 16 bits
  function automatic logic signed [15:0] ref_out(input longint x);
    longint      v;
    longint      r;
    logic [15:0] w;
    v = x + 64'sd8192;
    if (v >= 0) r = v / 16384;
    else        r = -((-v + 16383) / 16384);
`ifdef PRACH_MIXER_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    w = r[15:0];
    return w;
  endfunction

  // One cycle of stimulus.
  // sk[0] skews nco_chn by +1 and sk[1] flips nco_dv for this cycle.
  task automatic drive(input logic dv, input int i, input int q, input int ch,
                       input int c, input int s, input logic sy,
                       input int ei, input int eq,
                       input logic [1:0] sk, input logic clr);
    exp_t e;
    @(posedge clk);
    #1;
    din_dv   = dv;
    din_i    = 16'(i);
    din_q    = 16'(q);
    din_chn  = 8'(ch);
    sync_in  = sy;
    st_cos   = 16'(c);
    st_sin   = 16'(s);
    chn_skew = sk[0];
    dv_flip  = sk[1];
    err_clr  = clr;
    if (dv) begin
      e.i    = 16'(ei);
      e.q    = 16'(eq);
      e.chn  = 8'(ch);
      e.sync = sy;
      e.cyc  = cyc + LAT + 3;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b00, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && dout_dv) begin
        if (sbq.size() == 0) begin
          check("stray_dv", 1, 0);
        end else begin
          e = sbq.pop_front();
          $display("txn cyc=%0d ch=%0d i=%0d q=%0d sync=%0d", cyc, dout_chn, dout_i, dout_q, sync_out);
          check("dout_i", dout_i, e.i);
          check("dout_q", dout_q, e.q);
          check("dout_chn", dout_chn, e.chn);
          check("sync_out", sync_out, e.sync);
          check("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int cos_tab [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
  int sin_tab [8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

  initial begin : stim
    logic signed [15:0] ri;
    logic signed [15:0] rq;
    int ch;

    rst = 1'b1;
    din_i = '0; din_q = '0; din_dv = 1'b0; din_chn = '0; sync_in = 1'b0;
    st_cos = '0; st_sin = '0; chn_skew = 1'b0; dv_flip = 1'b0; err_clr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout_i", dout_i, 0);
    check("rst_dout_q", dout_q, 0);
    check("rst_dout_dv", dout_dv, 0);
    check("rst_dout_chn", dout_chn, 0);
    check("rst_sync_out", sync_out, 0);
    check("rst_align_err", align_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, expected values worked out by hand
    drive(1'b1, 100, -50, 3, 16384, 0, 1'b1, 100, -50, 2'b00, 1'b0);     // identity
    drive(1'b1, 100, 0, 0, 0, 16384, 1'b0, 0, -100, 2'b00, 1'b0);        // 90 deg
    drive(1'b1, 1, 0, 1, 8192, 0, 1'b0, 1, 0, 2'b00, 1'b0);              // +0.5 rounds up
    drive(1'b1, -1, 0, 2, 8192, 0, 1'b0, 0, 0, 2'b00, 1'b0);             // -0.5 rounds up to 0
    drive(1'b1, 32767, 32767, 7, 16384, 16384, 1'b0, OVF_P, 0, 2'b00, 1'b0);
    drive(1'b1, -32768, -32768, 6, 16384, 16384, 1'b0, OVF_N, 0, 2'b00, 1'b0);
    idle(10);
    @(negedge clk);
    check("align_err_directed", align_err, 0);

    // Interleaved streaming: 8 channels round-robin, continuous valid
    for (int k = 0; k < 32; k++) begin
      ch = k % 8;
      ri = 16'($urandom);
      rq = 16'($urandom);
      drive(1'b1, int'(ri), int'(rq), ch, cos_tab[ch], sin_tab[ch], (k == 0),
            int'(ref_out(longint'(ri) * cos_tab[ch] + longint'(rq) * sin_tab[ch])),
            int'(ref_out(longint'(rq) * cos_tab[ch] - longint'(ri) * sin_tab[ch])),
            2'b00, 1'b0);
    end
    idle(10);
    @(negedge clk);
    check("align_err_stream", align_err, 0);

    // Misalignment: nco_chn off by one for a single valid cycle
    for (int k = 0; k < 12; k++) begin
      ch = k % 8;
      drive(1'b1, 1000 + k, -k, ch, 16384, 0, 1'b0, 1000 + k, -k,
            {1'b0, (k == 6)}, 1'b0);
      if (k == 7) begin
        @(negedge clk);
        check("align_err_set", align_err, 1);
      end
    end
    idle(4);
    @(negedge clk);
    check("align_err_sticky", align_err, 1);
    drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b00, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b00, 1'b0);
    @(negedge clk);
    check("align_err_clr", align_err, 0);
    // Clear coincident with a new (dv) mismatch: set wins
    drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b10, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b00, 1'b0);
    @(negedge clk);
    check("align_err_set_wins", align_err, 1);
    drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b00, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 2'b00, 1'b0);
    @(negedge clk);
    check("align_err_clr2", align_err, 0);
    idle(8);

    // Reset mid-stream with 5 samples in flight
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 200 + k, 7, k, 16384, 0, 1'b0, 200 + k, 7, 2'b00, 1'b0);
    end
    #2;
    rst = 1'b1;
    din_dv = 1'b0;
    #1;
    check("mid_rst_dout_i", dout_i, 0);
    check("mid_rst_dout_q", dout_q, 0);
    check("mid_rst_dout_dv", dout_dv, 0);
    check("mid_rst_dout_chn", dout_chn, 0);
    check("mid_rst_sync_out", sync_out, 0);
    check("mid_rst_align_err", align_err, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_stale_dv", dout_dv, 0);
    end
    drive(1'b1, -300, 300, 5, 16384, 0, 1'b0, -300, 300, 2'b00, 1'b0);
    idle(10);
    @(negedge clk);
    check("align_err_after_rst", align_err, 0);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 50 && sbq.size() != 0; w++) @(negedge clk);
    check("drain", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
